// File: rtl/lebug_pkg.sv
// Shared constants and helpers for the vector packer and its firmware registers.
package lebug_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MAX_CHAINS = 4;

  localparam int FLUSH_EOF0 = 0;
  localparam int FLUSH_EOF1 = 1;

  localparam int LEN_BASE   = 0;
  localparam int FLUSH_BASE = DEF_MAX_CHAINS;

  typedef logic [DEF_DATA_WIDTH-1:0] lane_t;

  // Flush bytes follow the per-chain length bytes in the config stream.
  function automatic int flush_base(input int max_chains);
    return LEN_BASE + max_chains;
  endfunction

endpackage

// File: rtl/packer_config_regs.sv
// Per-chain firmware registers (lanes kept, flush mask) loaded from the config byte stream.
module packer_config_regs
  import lebug_pkg::*;
#(
  parameter int N = 8,
  parameter int MAX_CHAINS = 4,
  parameter int PERSONAL_CONFIG_ID = 0,
  parameter logic [7:0] INITIAL_FIRMWARE_LEN   [0:MAX_CHAINS-1] = '{default: 8'd0},
  parameter logic [7:0] INITIAL_FIRMWARE_FLUSH [0:MAX_CHAINS-1] = '{default: 8'd0},
  localparam int CHAIN_W = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1,
  localparam int LEN_W   = $clog2(N + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tracing,
  input  logic [7:0]         config_id,
  input  logic [7:0]         config_data,
  input  logic [CHAIN_W-1:0] chain,
  output logic [LEN_W-1:0]   keep_len,
  output logic [1:0]         flush_mask
);

  localparam int FLUSH_START = flush_base(MAX_CHAINS);

  logic [7:0] byte_counter;
  logic [7:0] len_regs   [0:MAX_CHAINS-1];
  logic [1:0] flush_regs [0:MAX_CHAINS-1];

  // The counter saturates so bytes past the flush block can never wrap onto a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_counter <= '0;
      for (int c = 0; c < MAX_CHAINS; c++) begin
        len_regs[c]   <= INITIAL_FIRMWARE_LEN[c];
        flush_regs[c] <= INITIAL_FIRMWARE_FLUSH[c][1:0];
      end
    end else if (tracing) begin
      byte_counter <= '0;
    end else if (config_id == 8'(PERSONAL_CONFIG_ID)) begin
      for (int c = 0; c < MAX_CHAINS; c++) begin
        if (int'(byte_counter) == LEN_BASE + c)    len_regs[c]   <= config_data;
        if (int'(byte_counter) == FLUSH_START + c) flush_regs[c] <= config_data[1:0];
      end
      if (byte_counter != 8'hFF) byte_counter <= byte_counter + 8'd1;
    end else begin
      byte_counter <= '0;
    end
  end

  // A length of zero or anything wider than a vector means keep every lane.
  always_comb begin
    keep_len = LEN_W'(N);
    if (len_regs[chain] != 8'd0 && len_regs[chain] <= 8'(N))
      keep_len = LEN_W'(len_regs[chain]);
    flush_mask = flush_regs[chain];
  end

endmodule

// File: rtl/vector_packer.sv
// Packs the leading lanes of each ALU vector densely into full N-lane trace words,
// flushing zero-padded partial words on firmware-selected end-of-frame flags.
module vector_packer
  import lebug_pkg::*;
#(
  parameter int N = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4,
  parameter int PERSONAL_CONFIG_ID = 0,
  parameter logic [7:0] INITIAL_FIRMWARE_LEN   [0:MAX_CHAINS-1] = '{default: 8'd0},
  parameter logic [7:0] INITIAL_FIRMWARE_FLUSH [0:MAX_CHAINS-1] = '{default: 8'd0}
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                tracing,
  input  logic                                valid_in,
  input  logic [1:0]                          eof_in,
  input  logic [1:0]                          bof_in,
  input  logic [$clog2(MAX_CHAINS)-1:0]       chainId_in,
  input  logic [7:0]                          configId,
  input  logic [7:0]                          configData,
  input  logic [N-1:0][DATA_WIDTH-1:0]        vector_in,
  output logic [N-1:0][DATA_WIDTH-1:0]        vector_out,
  output logic [$clog2(N+1)-1:0]              len_out,
  output logic                                valid_out,
  output logic [1:0]                          eof_out,
  output logic [1:0]                          bof_out
);

  localparam int CNT_W = $clog2(2 * N + 1);
  localparam int LEN_W = $clog2(N + 1);

  logic [LEN_W-1:0] keep_len;
  logic [1:0]       flush_mask;

  packer_config_regs #(
    .N                     (N),
    .MAX_CHAINS            (MAX_CHAINS),
    .PERSONAL_CONFIG_ID    (PERSONAL_CONFIG_ID),
    .INITIAL_FIRMWARE_LEN  (INITIAL_FIRMWARE_LEN),
    .INITIAL_FIRMWARE_FLUSH(INITIAL_FIRMWARE_FLUSH)
  ) u_config_regs (
    .clk        (clk),
    .rst        (rst),
    .tracing    (tracing),
    .config_id  (configId),
    .config_data(configData),
    .chain      (chainId_in),
    .keep_len   (keep_len),
    .flush_mask (flush_mask)
  );

  logic [DATA_WIDTH-1:0] lanes_q  [0:2*N-1];
  logic [DATA_WIDTH-1:0] lanes_d  [0:2*N-1];
  logic [DATA_WIDTH-1:0] emit_src [0:N-1];
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  pending_q, pending_d;
  logic [1:0]            word_bof_q, word_bof_d;
  logic [1:0]            last_eof_q, last_eof_d;
  logic                  emit;
  logic [LEN_W-1:0]      emit_len;
  logic [1:0]            emit_eof, emit_bof;
  logic                  flush_hit;
  int                    cnt;
  int                    keep;

  assign flush_hit = valid_in && ((flush_mask[FLUSH_EOF0] && eof_in[0]) ||
                                  (flush_mask[FLUSH_EOF1] && eof_in[1]));

  // One tracing cycle: drain a deferred flush, append, emit a full word, then honour a new flush.
  always_comb begin
    lanes_d    = lanes_q;
    pending_d  = pending_q;
    word_bof_d = word_bof_q;
    last_eof_d = last_eof_q;
    emit       = 1'b0;
    emit_len   = '0;
    emit_eof   = '0;
    emit_bof   = '0;
    for (int i = 0; i < N; i++) emit_src[i] = lanes_q[i];
    cnt  = int'(count_q);
    keep = int'(keep_len);
    if (tracing) begin
      if (pending_q) begin
        emit      = 1'b1;
        emit_len  = LEN_W'(cnt);
        emit_eof  = last_eof_q;
        emit_bof  = word_bof_q;
        cnt       = 0;
        pending_d = 1'b0;
      end
      if (valid_in) begin
        if (cnt == 0) word_bof_d = bof_in;
        last_eof_d = eof_in;
        for (int j = 0; j < 2 * N; j++)
          for (int i = 0; i < N; i++)
            if (i < keep && j == cnt + i) lanes_d[j] = vector_in[i];
        cnt = cnt + keep;
      end
      // The leftover lanes after a full word always belong to the vector just appended.
      if (!emit && cnt >= N) begin
        emit     = 1'b1;
        emit_len = LEN_W'(N);
        emit_eof = last_eof_d;
        emit_bof = word_bof_d;
        for (int i = 0; i < N; i++) begin
          emit_src[i]    = lanes_d[i];
          lanes_d[i]     = lanes_d[i+N];
          lanes_d[i+N]   = '0;
        end
        cnt        = cnt - N;
        word_bof_d = bof_in;
      end
      if (flush_hit && cnt > 0) begin
        if (!emit) begin
          emit     = 1'b1;
          emit_len = LEN_W'(cnt);
          emit_eof = eof_in;
          emit_bof = word_bof_d;
          for (int i = 0; i < N; i++) emit_src[i] = lanes_d[i];
          cnt = 0;
        end else begin
          pending_d = 1'b1;
        end
      end
    end
    count_d = CNT_W'(cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < 2 * N; j++) lanes_q[j] <= '0;
      count_q    <= '0;
      pending_q  <= 1'b0;
      word_bof_q <= '0;
      last_eof_q <= '0;
      vector_out <= '0;
      len_out    <= '0;
      valid_out  <= 1'b0;
      eof_out    <= '0;
      bof_out    <= '0;
    end else begin
      lanes_q    <= lanes_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      word_bof_q <= word_bof_d;
      last_eof_q <= last_eof_d;
      valid_out  <= emit;
      if (emit) begin
        len_out <= emit_len;
        eof_out <= emit_eof;
        bof_out <= emit_bof;
        for (int i = 0; i < N; i++)
          vector_out[i] <= (i < int'(emit_len)) ? emit_src[i] : '0;
      end
    end
  end

endmodule

// File: doc/vector_packer.md
Name: vector_packer

Overview:
- Sits directly downstream of the vector-vector ALU stage.
- Consumes its N-lane vector stream (vector, valid, chainId, eof/bof) and keeps a per-chain, firmware-selected number of leading lanes from each vector.
- Packs the kept lanes densely into full N-lane words for the trace buffer, so scalar or short results do not waste trace memory.
- Partial words are flushed, zero-padded, on configurable end-of-frame conditions.

Parameters:
- N, 8, lanes per vector (input and output).
- DATA_WIDTH, 32, bits per lane.
- MAX_CHAINS, 4, number of firmware chains.
- PERSONAL_CONFIG_ID, 0, configId value that addresses this block.
- INITIAL_FIRMWARE_LEN [0:MAX_CHAINS-1], all 0, reset/initial lanes-kept per chain.
- INITIAL_FIRMWARE_FLUSH [0:MAX_CHAINS-1], all 0, reset/initial flush condition per chain.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- tracing  in  1  1 = trace mode, 0 = configuration mode.
- valid_in  in  1  input vector valid.
- eof_in  in  2  end-of-frame flags, level 0 and level 1.
- bof_in  in  2  begin-of-frame flags; passed to bof_out on emitted words.
- chainId_in  in  $clog2(MAX_CHAINS)  chain of the current input.
- configId  in  8  configuration target id.
- configData  in  8  configuration byte.
- vector_in  in  N x DATA_WIDTH  input lanes; lane 0 is first.
- vector_out  out  N x DATA_WIDTH  packed word.
- len_out  out  $clog2(N+1)  number of valid lanes in vector_out (1..N).
- valid_out  out  1  packed word valid.
- eof_out  out  2  eof_in of the vector that completed or flushed the word.
- bof_out  out  2  bof_in of the first vector contributing to the word.

Behaviour:
- Reset:
  - vector_out=0, len_out=0, valid_out=0, eof_out=0, bof_out=0.
  - Buffer count=0, byte_counter=0, pending_flush=0.
  - Firmware arrays reload their INITIAL_* values.
- Firmware per chain:
  - len k: 0 means N; values >N saturate to N; keep lanes 0..k-1.
  - flush byte: bit0 flushes on eof_in[0]=1; bit1 flushes on eof_in[1]=1; 0 never flushes.
- Configuration (tracing=0):
  - valid_in is ignored and valid_out=0.
  - If configId==PERSONAL_CONFIG_ID: byte_counter increments each cycle. Bytes 0..MAX_CHAINS-1 write len[chain]; bytes MAX_CHAINS..2*MAX_CHAINS-1 write flush[chain]; later bytes are ignored.
  - Otherwise byte_counter resets to 0.
  - Buffer contents are retained across configuration.
- Buffer: 2N lanes plus count register (0..2N).
- Each tracing cycle, in this order:
  1. If pending_flush: emit lanes 0..count-1 with zero padding, len_out=count, valid_out=1. Set count=0 and clear pending_flush. No second emit occurs this cycle.
  2. If valid_in: append k lanes at position count.
  3. If no emit happened in step 1 and count>=N: emit lanes 0..N-1, len_out=N, shift the remainder down, count-=N.
  4. If valid_in and the flush condition holds and count>0:
     - If step 3 did not emit, emit the remainder now, zero-padded, with len_out=count, and set count=0.
     - If step 3 did emit, set pending_flush.
  5. A flush with an empty buffer emits nothing.
- Latency: one cycle.
  - A word completed by the input at cycle t shows valid_out=1 at t+1.
  - Outputs are registered.
  - valid_out is a single-cycle pulse. There is no backpressure.
- Invariants:
  - count<=N after every cycle, except a pending-flush cycle whose append may leave count=N. That word emits the next cycle.
  - Throughput: one input per cycle sustained, never drops data.
- Reset mid-operation discards buffered lanes without emitting them.

Decomposition:
- Shared package (lebug_pkg):
  - Flush-bit constants FLUSH_EOF0=0 and FLUSH_EOF1=1.
  - Config byte layout constants LEN_BASE=0 and FLUSH_BASE=MAX_CHAINS.
  - Lane-array typedef helper.
- One natural sub-module: packer_config_regs, holding the byte_counter and per-chain firmware arrays, with chain-indexed read ports.
- The packing datapath and emit logic stay in vector_packer.

Test Plan:
- Full lanes: N=8, chain0 len=0, inputs 1..8 then 9..16 on consecutive cycles -> two words, each one cycle after its input; len_out=8 for both.
- Scalar packing: chain1 len=1, eight inputs with lane0 = 10,20,...,80 -> exactly one word {10,...,80} after the 8th input; valid_out stays 0 on the earlier cycles.
- Straddle: len=3, inputs A,B,C -> after C emit {A0,A1,A2,B0,B1,B2,C0,C1}; count=1 holding C2.
- Flush: then input D (len=3) with eof_in[0]=1 and flush=1 -> count reaches 4 -> emit {C2,D0,D1,D2,0,0,0,0}, len_out=4. Separately, with count=7, a len=3 input with flush -> full word at t+1, remainder 2 lanes with len_out=2 at t+2.
- Config: tracing=0, configId=PERSONAL_CONFIG_ID, bytes {2,0,0,0,1,0,0,0} -> len[0]=2, flush[0]=1 verified by trace behaviour; bytes 8+ have no effect; valid_out=0 throughout.
- Reset: assert rst with count=5 -> next cycle count=0 and all outputs zero; an eof flush afterwards emits nothing.
